mem_port_arbiter: RTL and testbench

Shares one single-ported unified instruction/data memory between the Fetch stage (I port) and the Memory stage (D port) of the pipelined core. Runs a small FSM that issues one memory transaction at a time and registers the read data. Drives per-port done pulses, from which the hazard logic derives StallF and StallM. By default the D port wins conflicts, because it belongs to the older instruction.

---
 rtl/mem_port_arbiter_if.sv | 39 +++
 rtl/mem_port_arbiter.sv | 112 +++++++++++
 tb/tb_mem_port_arbiter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - I/D request ports and shared memory bus of mem_port_arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_done;

  logic                i_unused_pad;
  logic                d_req;
  logic                d_we;
  logic [DATA_W/8-1:0] d_be;
  logic [ADDR_W-1:0]   d_addr;
  logic [DATA_W-1:0]   d_wdata;
  logic [DATA_W-1:0]   d_rdata;
  logic                d_done;

  logic                mem_req;
  logic                mem_we;
  logic [DATA_W/8-1:0] mem_be;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_rdata;
  logic                mem_ready;

  // arbiter side
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata, mem_ready,
    output i_rdata, i_done, d_rdata, d_done, mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );

  // core pipeline and memory model side
  modport master (
    output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata, mem_ready,
    input  i_rdata, i_done, d_rdata, d_done, mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - I/D arbiter for one single-ported unified memory, D priority
// Optional fetch-starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave bus
);
  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [BE_W-1:0]   be_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              i_done_q;
  logic              d_done_q;

  logic starve;
  logic grant_d;
  logic grant_i;

`ifdef ARB_STARVE_GUARD_EN
  localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  logic [WAIT_W-1:0] wait_q;
  assign starve = (wait_q == WAIT_W'(MAX_WAIT));
`else
  localparam int unused_max_wait = MAX_WAIT;
  assign starve = 1'b0;
`endif

  always_comb begin
    grant_d = bus.d_req & ~(bus.i_req & starve);
    grant_i = bus.i_req & ~grant_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      we_q      <= 1'b0;
      be_q      <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
`ifdef ARB_STARVE_GUARD_EN
      wait_q    <= '0;
`endif
    end else begin
      i_done_q <= 1'b0;
      d_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_d) begin
            state_q <= BUSY_D;
            addr_q  <= bus.d_addr;
            we_q    <= bus.d_we;
            be_q    <= bus.d_be;
            wdata_q <= bus.d_wdata;
`ifdef ARB_STARVE_GUARD_EN
            if (bus.i_req && !starve) wait_q <= wait_q + 1'b1;
`endif
          end else if (grant_i) begin
            // fetches are always full-word reads
            state_q <= BUSY_I;
            addr_q  <= bus.i_addr;
            we_q    <= 1'b0;
            be_q    <= '1;
            wdata_q <= '0;
`ifdef ARB_STARVE_GUARD_EN
            wait_q  <= '0;
`endif
          end
        end
        BUSY_I: begin
          if (bus.mem_ready) begin
            state_q   <= IDLE;
            i_rdata_q <= bus.mem_rdata;
            i_done_q  <= 1'b1;
          end
        end
        BUSY_D: begin
          if (bus.mem_ready) begin
            state_q   <= IDLE;
            d_rdata_q <= bus.mem_rdata;
            d_done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_req   = (state_q != IDLE);
  assign bus.mem_we    = we_q;
  assign bus.mem_be    = be_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.i_done    = i_done_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_done    = d_done_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_req     = 1'b0;
    bus.i_addr    = '0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_be      = '0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.mem_rdata = '0;
    bus.mem_ready = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    bus.i_unused_pad = 1'b0;
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_i_done", bus.i_done, 0);
    check("rst_d_done", bus.d_done, 0);
    check("rst_d_rdata", bus.d_rdata, 0);
    rst_n = 1'b1;
    step();

    // reset dropped in the middle of a D transaction
    bus.d_req  = 1'b1;
    bus.d_addr = 32'h0000_0400;
    step();
    check("t1_busy", bus.mem_req, 1);
    #3 rst_n = 1'b0;
    #1;
    check("t1_async_mem_req", bus.mem_req, 0);
    check("t1_async_d_done", bus.d_done, 0);
    check("t1_async_i_done", bus.i_done, 0);
    idle_inputs();
    step();
    rst_n = 1'b1;
    bus.mem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("t1_post_mem_req", bus.mem_req, 0);
      check("t1_post_d_done", bus.d_done, 0);
      check("t1_post_i_done", bus.i_done, 0);
    end

    // single fetch, zero-wait memory
    bus.i_req     = 1'b1;
    bus.i_addr    = 32'h0000_0010;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h0050_0093;
    step();
    check("t2_mem_req", bus.mem_req, 1);
    check("t2_mem_addr", bus.mem_addr, 32'h10);
    check("t2_mem_we", bus.mem_we, 0);
    check("t2_mem_be", bus.mem_be, 4'hF);
    check("t2_i_done_early", bus.i_done, 0);
    step();
    check("t2_i_done", bus.i_done, 1);
    check("t2_i_rdata", bus.i_rdata, 32'h0050_0093);
    check("t2_mem_req_idle", bus.mem_req, 0);
    bus.i_req = 1'b0;
    step();
    check("t2_i_done_pulse", bus.i_done, 0);
    check("t2_no_regrant", bus.mem_req, 0);

    // store with delayed mem_ready; addr change after grant is ignored
    bus.mem_ready = 1'b0;
    bus.d_req     = 1'b1;
    bus.d_we      = 1'b1;
    bus.d_be      = 4'b0011;
    bus.d_addr    = 32'h0000_0100;
    bus.d_wdata   = 32'hDEAD_BEEF;
    step();
    bus.d_addr = 32'h0000_0999;
    for (int k = 0; k < 3; k++) begin
      check("t3_mem_req", bus.mem_req, 1);
      check("t3_mem_we", bus.mem_we, 1);
      check("t3_mem_be", bus.mem_be, 4'b0011);
      check("t3_mem_addr", bus.mem_addr, 32'h100);
      check("t3_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
      check("t3_d_done_wait", bus.d_done, 0);
      if (k == 2) bus.mem_ready = 1'b1;
      step();
    end
    check("t3_d_done", bus.d_done, 1);
    check("t3_i_done", bus.i_done, 0);
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.mem_ready = 1'b0;
    step();
    check("t3_d_done_pulse", bus.d_done, 0);
    check("t3_idle", bus.mem_req, 0);

    // simultaneous requests: D first, I granted in D's done cycle
    bus.i_req     = 1'b1;
    bus.i_addr    = 32'h0000_0040;
    bus.d_req     = 1'b1;
    bus.d_addr    = 32'h0000_0200;
    bus.d_be      = 4'hF;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h0000_1234;
    step();
    check("t4_d_first_addr", bus.mem_addr, 32'h200);
    check("t4_d_first_we", bus.mem_we, 0);
    step();
    check("t4_d_done", bus.d_done, 1);
    check("t4_d_rdata", bus.d_rdata, 32'h1234);
    check("t4_i_not_done", bus.i_done, 0);
    bus.d_req     = 1'b0;
    bus.mem_rdata = 32'h0000_ABCD;
    step();
    check("t4_i_grant_req", bus.mem_req, 1);
    check("t4_i_grant_addr", bus.mem_addr, 32'h40);
    check("t4_i_grant_be", bus.mem_be, 4'hF);
    step();
    check("t4_i_done", bus.i_done, 1);
    check("t4_i_rdata", bus.i_rdata, 32'hABCD);
    check("t4_d_rdata_hold", bus.d_rdata, 32'h1234);
    bus.i_req = 1'b0;
    step();

    // both ports held: grant order depends on the starvation guard
    bus.i_req     = 1'b1;
    bus.i_addr    = 32'h0000_0080;
    bus.d_req     = 1'b1;
    bus.d_addr    = 32'h0000_0300;
    bus.mem_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      logic exp_i;
`ifdef ARB_STARVE_GUARD_EN
      exp_i = ((k % 4) == 3);
`else
      exp_i = 1'b0;
`endif
      step();
      check("t5_grant_addr", bus.mem_addr, exp_i ? 32'h80 : 32'h300);
      step();
      check("t5_i_done", bus.i_done, exp_i);
      check("t5_d_done", bus.d_done, !exp_i);
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    step();
    step();
    check("t5_drain", bus.mem_req, 0);

    // back-to-back fetch stream, address advances on each i_done
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h0000_0000;
    for (int k = 0; k < 3; k++) begin
      step();
      check("t6_mem_addr", bus.mem_addr, 32'(4 * k));
      check("t6_i_done_gap", bus.i_done, 0);
      step();
      check("t6_i_done", bus.i_done, 1);
      check("t6_no_d_done", bus.d_done, 0);
      bus.i_addr = 32'(4 * (k + 1));
    end
    bus.i_req = 1'b0;
    step();
    check("t6_end_done", bus.i_done, 0);
    check("t6_end_req", bus.mem_req, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
